md_init_loader: RTL and testbench
=================================

// Module: md_init_loader
// PURPOSE
// - Next-generation particle-cache initialiser: unpacks an AXI4-Stream of packed particle records into per-cell position/element writes.
// - Sits between the host/DMA init stream and the per-cell position caches, ahead of the force pipeline.
// - Generalises the single-count loader:
//   - per-cell particle counts;
//   - true tready backpressure;
//   - per-lane write masking;
//   - zero-count group skipping;
//   - tlast checking;
//   - start/busy/done control.
// PARAMETERS
// NUM_CELLS          8    cells loaded; must be a multiple of LANES
// LANES              4    particle records (sub-packets) per beat = cells written per group
// PARTICLE_ID_WIDTH  8    per-cell address / count width
// OFFSET_WIDTH       23   per-axis fixed-point offset width
// ELEMENT_WIDTH      2    element-type field width
// SUB_PACKET_WIDTH   128  record pitch: x@0, y@32, z@64, element@96 within a record
// NUM_GROUPS = NUM_CELLS/LANES, AXIS_W = LANES*SUB_PACKET_WIDTH (derived localparams)
// PORTS
// clk            in   1                          clock
// rst            in   1                          synchronous, active-high reset
// i_start        in   1                          pulse: latch i_npc and begin a load (ignored unless IDLE or DONE)
// i_npc          in   NUM_CELLS*PARTICLE_ID_WIDTH  particle count per cell, sampled on accepted i_start
// s_axis_tdata   in   AXIS_W                     lane k = record for cell g*LANES+k
// s_axis_tvalid  in   1                          beat valid
// s_axis_tlast   in   1                          marks final beat of the whole load
// s_axis_tready  out  1                          beat accepted when tvalid & tready
// o_wr_addr      out  PARTICLE_ID_WIDTH          cache write address, common to all cells
// o_wr_data      out  NUM_CELLS*3*OFFSET_WIDTH   {z,y,x} offsets per cell
// o_wr_element   out  NUM_CELLS*ELEMENT_WIDTH    element per cell
// o_wr_en        out  NUM_CELLS                  per-cell write enable
// o_busy         out  1                          high in SKIP/LOAD
// o_done         out  1                          high in DONE until next accepted i_start
// o_err_tlast    out  1                          sticky; cleared on accepted i_start
// BEHAVIOUR
// - Reset: FSM=IDLE; every output = 0, including tready and the sticky error; internal group/addr counters = 0.
// - FSM states: IDLE, SKIP, LOAD, DONE.
//   - IDLE/DONE + i_start: latch i_npc, grp=0, addr=0, clear err/done -> SKIP.
//   - SKIP (1 cycle per group, tready=0):
//     - gmax = max i_npc over cells of group grp.
//     - gmax==0 and grp==NUM_GROUPS-1 -> DONE.
//     - gmax==0 otherwise -> grp+1, stay SKIP.
//     - gmax!=0 -> LOAD.
//   - LOAD: tready=1; each accepted beat writes address addr.
//     - addr==gmax-1 and grp==NUM_GROUPS-1 -> DONE.
//     - addr==gmax-1 otherwise -> addr=0, grp+1 -> SKIP.
//     - Else addr+1.
// - Beats: exactly sum over groups of gmax beats consumed; no beats consumed for all-zero groups.
// - Lane masking: lane k is written only if addr < npc[g*LANES+k]; beats beyond a shorter cell's count write nothing to it.
// - Write latency: registered, 1 cycle after acceptance.
//   - o_wr_addr, o_wr_data, o_wr_element and o_wr_en all update together.
//   - o_wr_en is 0 in every cycle with no accepted beat.
//   - Data lanes of unselected cells hold 0.
// - o_done: rises in the same cycle the final beat's write enables appear on the outputs.
// - An all-zero load reaches DONE after NUM_GROUPS SKIP cycles with no writes.
// - tlast check: o_err_tlast is set when
//   - tlast=1 on any accepted beat that is not the final beat, or
//   - tlast=0 on the final beat.
//   - Loading continues regardless of the error.
// - i_start while busy: ignored.
// - rst mid-load: immediate return to reset state; partial cache contents are not cleaned.
// - Counters: addr counter is PARTICLE_ID_WIDTH bits; gmax <= 2^W-1, so addr never wraps.
// STRUCTURE
// - MD_pkg holds:
//   - LANES, SUB_PACKET_WIDTH, field bit offsets (X_LSB=0, Y_LSB=32, Z_LSB=64, ELEM_LSB=96);
//   - typedef init_rec_t {element, z, y, x}.
// - Sub-module md_init_lane_unpack: combinational record -> init_rec_t slice extractor, instantiated LANES times.
// - Top level: FSM, counters, group-max reduction, masking, output registers.
// TESTING
// - NUM_CELLS=8, LANES=4, all npc=3, tlast on beat 6 -> 6 beats accepted.
//   - Beats 1-3: o_wr_en=0x0F, addr 0,1,2.
//   - Beats 4-6: o_wr_en=0xF0, addr 0,1,2.
//   - o_done on beat 6's write; err=0.
// - npc={0,0,0,0,2,1,0,5} (cell0 first) -> group0 skipped with no beats; 5 beats in group1.
//   - o_wr_en: 0xB0, 0x90, 0x80, 0x80, 0x80.
// - All npc=0 after i_start -> tready never high; o_done rises 2 cycles after SKIP entry; no o_wr_en.
// - tvalid toggled 1-0-1 with random gaps, all npc=2 -> exactly 4 writes; addresses/data match the accepted beats only.
// - All npc=1, tlast on beat 1 -> o_err_tlast=1 after beat 1, and both beats are still written.
//   - Next i_start clears the error.
// - rst asserted mid-group1 -> next cycle all outputs 0 and FSM=IDLE.
//   - A fresh i_start then completes a normal load.

Source files
------------

// File: rtl/md_init_loader_pkg.sv
// rtl/md_init_loader_pkg.sv - record layout, lane geometry and FSM states for the init loader
package md_init_loader_pkg;

  localparam int LANES            = 4;
  localparam int SUB_PACKET_WIDTH = 128;
  localparam int OFFSET_WIDTH     = 23;
  localparam int ELEMENT_WIDTH    = 2;

  localparam int X_LSB    = 0;
  localparam int Y_LSB    = 32;
  localparam int Z_LSB    = 64;
  localparam int ELEM_LSB = 96;

  typedef struct packed {
    logic [ELEMENT_WIDTH-1:0] element;
    logic [OFFSET_WIDTH-1:0]  z;
    logic [OFFSET_WIDTH-1:0]  y;
    logic [OFFSET_WIDTH-1:0]  x;
  } init_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SKIP = 2'd1,
    ST_LOAD = 2'd2,
    ST_DONE = 2'd3
  } load_state_t;

endpackage

// File: rtl/md_init_lane_unpack.sv
// rtl/md_init_lane_unpack.sv - slices one packed particle record into its fields
module md_init_lane_unpack
  import md_init_loader_pkg::*;
(
  input  logic [SUB_PACKET_WIDTH-1:0] rec_data,
  output init_rec_t                   rec
);

  logic unused_pad;

  assign rec.x       = rec_data[X_LSB +: OFFSET_WIDTH];
  assign rec.y       = rec_data[Y_LSB +: OFFSET_WIDTH];
  assign rec.z       = rec_data[Z_LSB +: OFFSET_WIDTH];
  assign rec.element = rec_data[ELEM_LSB +: ELEMENT_WIDTH];

  // Padding between fields carries no information.
  assign unused_pad = ^{rec_data[SUB_PACKET_WIDTH-1:ELEM_LSB+ELEMENT_WIDTH],
                        rec_data[ELEM_LSB-1:Z_LSB+OFFSET_WIDTH],
                        rec_data[Z_LSB-1:Y_LSB+OFFSET_WIDTH],
                        rec_data[Y_LSB-1:X_LSB+OFFSET_WIDTH]};

endmodule

// File: rtl/md_init_loader.sv
// rtl/md_init_loader.sv - unpacks the init stream into masked per-cell position-cache writes
module md_init_loader
  import md_init_loader_pkg::*;
#(
  parameter int NUM_CELLS         = 8,
  parameter int PARTICLE_ID_WIDTH = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    i_start,
  input  logic [NUM_CELLS*PARTICLE_ID_WIDTH-1:0]  i_npc,
  input  logic [LANES*SUB_PACKET_WIDTH-1:0]       s_axis_tdata,
  input  logic                                    s_axis_tvalid,
  input  logic                                    s_axis_tlast,
  output logic                                    s_axis_tready,
  output logic [PARTICLE_ID_WIDTH-1:0]            o_wr_addr,
  output logic [NUM_CELLS*3*OFFSET_WIDTH-1:0]     o_wr_data,
  output logic [NUM_CELLS*ELEMENT_WIDTH-1:0]      o_wr_element,
  output logic [NUM_CELLS-1:0]                    o_wr_en,
  output logic                                    o_busy,
  output logic                                    o_done,
  output logic                                    o_err_tlast
);

  localparam int NUM_GROUPS = NUM_CELLS / LANES;
  localparam int GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int CELL_DW    = 3 * OFFSET_WIDTH;
  localparam int W          = PARTICLE_ID_WIDTH;
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NUM_GROUPS - 1);

  load_state_t state, state_nxt;
  logic [GRP_W-1:0]             grp, grp_nxt;
  logic [W-1:0]                 addr, addr_nxt;
  logic [NUM_CELLS*W-1:0]       npc_q;
  logic [W-1:0]                 gmax;
  logic                         rest_zero;
  logic                         err_q;
  logic                         start_ok, accept, group_end, final_beat;
  logic [NUM_CELLS-1:0]         in_grp, lane_sel;
  logic [NUM_CELLS*CELL_DW-1:0] wr_data_nxt;
  logic [NUM_CELLS*ELEMENT_WIDTH-1:0] wr_elem_nxt;
  init_rec_t                    rec [LANES];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    md_init_lane_unpack u_unpack (
      .rec_data (s_axis_tdata[k*SUB_PACKET_WIDTH +: SUB_PACKET_WIDTH]),
      .rec      (rec[k])
    );
  end

  for (genvar c = 0; c < NUM_CELLS; c++) begin : g_cell
    localparam int L = c % LANES;
    localparam logic [GRP_W-1:0] CG = GRP_W'(c / LANES);
    logic [W-1:0] cnt;
    assign cnt         = npc_q[c*W +: W];
    assign in_grp[c]   = (grp == CG);
    // A cell shorter than its group's longest cell stops being written once addr reaches its count.
    assign lane_sel[c] = accept && in_grp[c] && (addr < cnt);
    assign wr_data_nxt[c*CELL_DW +: CELL_DW] =
      lane_sel[c] ? {rec[L].z, rec[L].y, rec[L].x} : '0;
    assign wr_elem_nxt[c*ELEMENT_WIDTH +: ELEMENT_WIDTH] =
      lane_sel[c] ? rec[L].element : '0;
  end

  // Longest cell in the current group, and whether every later group is empty.
  always_comb begin
    gmax      = '0;
    rest_zero = 1'b1;
    for (int c = 0; c < NUM_CELLS; c++) begin
      if (in_grp[c] && (npc_q[c*W +: W] > gmax)) gmax = npc_q[c*W +: W];
      if (((c / LANES) > int'(grp)) && (npc_q[c*W +: W] != '0)) rest_zero = 1'b0;
    end
  end

  assign s_axis_tready = (state == ST_LOAD);
  assign o_busy        = (state == ST_SKIP) || (state == ST_LOAD);
  assign o_done        = (state == ST_DONE);
  assign o_err_tlast   = err_q;

  assign start_ok   = i_start && ((state == ST_IDLE) || (state == ST_DONE));
  assign accept     = s_axis_tvalid && s_axis_tready;
  assign group_end  = (addr == gmax - 1'b1);
  // Trailing all-zero groups still cost SKIP cycles but carry no beats.
  assign final_beat = group_end && rest_zero;

  always_comb begin
    state_nxt = state;
    grp_nxt   = grp;
    addr_nxt  = addr;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_nxt = ST_SKIP;
          grp_nxt   = '0;
          addr_nxt  = '0;
        end
      end
      ST_SKIP: begin
        if (gmax == '0) begin
          if (grp == LAST_GRP) state_nxt = ST_DONE;
          else                 grp_nxt   = grp + 1'b1;
        end else begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (group_end) begin
            addr_nxt = '0;
            if (grp == LAST_GRP) begin
              state_nxt = ST_DONE;
            end else begin
              grp_nxt   = grp + 1'b1;
              state_nxt = ST_SKIP;
            end
          end else begin
            addr_nxt = addr + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      grp          <= '0;
      addr         <= '0;
      npc_q        <= '0;
      err_q        <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_wr_element <= '0;
      o_wr_en      <= '0;
    end else begin
      state   <= state_nxt;
      grp     <= grp_nxt;
      addr    <= addr_nxt;
      o_wr_en <= lane_sel;
      if (start_ok) begin
        npc_q <= i_npc;
        err_q <= 1'b0;
      end else if (accept && (s_axis_tlast != final_beat)) begin
        err_q <= 1'b1;
      end
      if (accept) begin
        o_wr_addr    <= addr;
        o_wr_data    <= wr_data_nxt;
        o_wr_element <= wr_elem_nxt;
      end
    end
  end

endmodule

// File: tb/tb_md_init_loader.sv
// tb/tb_md_init_loader.sv - directed table-driven bench for md_init_loader
module tb_md_init_loader;

  logic         clk;
  logic         rst;
  logic         i_start;
  logic [63:0]  i_npc;
  logic [511:0] s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic         s_axis_tready;
  logic [7:0]   o_wr_addr;
  logic [551:0] o_wr_data;
  logic [15:0]  o_wr_element;
  logic [7:0]   o_wr_en;
  logic         o_busy;
  logic         o_done;
  logic         o_err_tlast;

  int checks = 0;
  int errors = 0;

  md_init_loader #(.NUM_CELLS(8), .PARTICLE_ID_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_npc         (i_npc),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .o_wr_addr     (o_wr_addr),
    .o_wr_data     (o_wr_data),
    .o_wr_element  (o_wr_element),
    .o_wr_en       (o_wr_en),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err_tlast   (o_err_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]   en;
    logic [7:0]   addr;
    logic [551:0] data;
    logic [15:0]  elem;
    logic         done;
  } wr_t;

  typedef struct {
    logic [63:0] npc;
    int          beats;
    int          tlast_at;
    int          gaps;
    logic [47:0] en;
    logic [47:0] addr;
    logic        err;
  } vec_t;

  wr_t          cap[$];
  logic [511:0] sent[$];

  always @(negedge clk) begin
    if (!rst && (o_wr_en != 8'h00))
      cap.push_back('{en: o_wr_en, addr: o_wr_addr, data: o_wr_data, elem: o_wr_element, done: o_done});
  end

  task automatic chk(input string nm, input logic [575:0] act, input logic [575:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] rand_beat();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic void exp_write(input logic [511:0] b, input logic [7:0] en,
                                    output logic [551:0] d, output logic [15:0] e);
    int l;
    d = '0;
    e = '0;
    for (int c = 0; c < 8; c++) begin
      if (en[c]) begin
        l = c % 4;
        d[c*69      +: 23] = b[l*128      +: 23];
        d[c*69 + 23 +: 23] = b[l*128 + 32 +: 23];
        d[c*69 + 46 +: 23] = b[l*128 + 64 +: 23];
        e[c*2 +: 2]        = b[l*128 + 96 +: 2];
      end
    end
  endfunction

  function automatic vec_t mk(input logic [63:0] npc, input int beats, input int tl, input int gaps,
                              input logic [47:0] en, input logic [47:0] addr, input logic err);
    vec_t v;
    v.npc = npc; v.beats = beats; v.tlast_at = tl; v.gaps = gaps;
    v.en = en; v.addr = addr; v.err = err;
    return v;
  endfunction

  // Called at a negedge; offers beats until n are accepted, the load finishes or the budget runs out.
  task automatic send_beats(input int n, input int tlast_at, input int gaps, output int got);
    logic [511:0] cur;
    logic         acc;
    int           cyc;
    got = 0;
    cyc = 0;
    cur = rand_beat();
    while ((got < n) && (cyc < 400) && !o_done) begin
      s_axis_tvalid = (gaps != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
      s_axis_tdata  = cur;
      s_axis_tlast  = ((got + 1) == tlast_at);
      acc = s_axis_tvalid && s_axis_tready;
      @(negedge clk);
      cyc++;
      if (acc) begin
        sent.push_back(cur);
        got++;
        cur = rand_beat();
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    int           got;
    int           cyc;
    logic [551:0] ed;
    logic [15:0]  ee;
    sent.delete();
    cap.delete();
    i_npc   = v.npc;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk($sformatf("v%0d_err_cleared", vi), o_err_tlast, 1'b0);
    chk($sformatf("v%0d_busy", vi), o_busy, 1'b1);
    send_beats(v.beats, v.tlast_at, v.gaps, got);
    cyc = 0;
    while (!o_done && (cyc < 50)) begin
      @(negedge clk);
      cyc++;
    end
    #1;
    chk($sformatf("v%0d_done", vi), o_done, 1'b1);
    chk($sformatf("v%0d_beats", vi), got, v.beats);
    chk($sformatf("v%0d_writes", vi), cap.size(), v.beats);
    for (int j = 0; (j < cap.size()) && (j < v.beats) && (j < sent.size()); j++) begin
      exp_write(sent[j], v.en[j*8 +: 8], ed, ee);
      chk($sformatf("v%0d_en%0d", vi, j), cap[j].en, v.en[j*8 +: 8]);
      chk($sformatf("v%0d_addr%0d", vi, j), cap[j].addr, v.addr[j*8 +: 8]);
      chk($sformatf("v%0d_data%0d", vi, j), cap[j].data, ed);
      chk($sformatf("v%0d_elem%0d", vi, j), cap[j].elem, ee);
      chk($sformatf("v%0d_done_at%0d", vi, j), cap[j].done, (j == v.beats - 1));
    end
    chk($sformatf("v%0d_err", vi), o_err_tlast, v.err);
    chk($sformatf("v%0d_tready_idle", vi), s_axis_tready, 1'b0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_en"}, o_wr_en, 8'h00);
    chk({nm, "_addr"}, o_wr_addr, 8'h00);
    chk({nm, "_data"}, o_wr_data, 552'h0);
    chk({nm, "_elem"}, o_wr_element, 16'h0);
    chk({nm, "_tready"}, s_axis_tready, 1'b0);
    chk({nm, "_busy"}, o_busy, 1'b0);
    chk({nm, "_done"}, o_done, 1'b0);
    chk({nm, "_err"}, o_err_tlast, 1'b0);
  endtask

  vec_t vecs[7];

  initial begin
    int got;

    vecs[0] = mk(64'h0303030303030303, 6, 6, 0, 48'hF0F0F00F0F0F, 48'h020100020100, 1'b0);
    vecs[1] = mk(64'h0500010200000000, 5, 5, 0, 48'h80808090B0, 48'h0403020100, 1'b0);
    vecs[2] = mk(64'h0000000000000000, 0, 0, 0, 48'h0, 48'h0, 1'b0);
    vecs[3] = mk(64'h0202020202020202, 4, 4, 1, 48'hF0F00F0F, 48'h01000100, 1'b0);
    vecs[4] = mk(64'h0101010101010101, 2, 1, 0, 48'hF00F, 48'h0000, 1'b1);
    vecs[5] = mk(64'h0101010101010101, 2, 0, 0, 48'hF00F, 48'h0000, 1'b1);
    vecs[6] = mk(64'h0000000100000000, 1, 1, 0, 48'h10, 48'h00, 1'b0);

    rst = 1'b1; i_start = 1'b0; i_npc = '0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // All-zero load: two SKIP cycles, then DONE, never ready, never writing.
    cap.delete();
    i_npc = '0; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("zero_skip0_busy", o_busy, 1'b1);
    chk("zero_skip0_done", o_done, 1'b0);
    chk("zero_skip0_tready", s_axis_tready, 1'b0);
    @(negedge clk);
    chk("zero_skip1_busy", o_busy, 1'b1);
    chk("zero_skip1_done", o_done, 1'b0);
    chk("zero_skip1_tready", s_axis_tready, 1'b0);
    @(negedge clk);
    chk("zero_done", o_done, 1'b1);
    chk("zero_done_busy", o_busy, 1'b0);
    #1;
    chk("zero_no_writes", cap.size(), 0);

    // Start while busy is ignored; reset mid-group1 returns everything to zero.
    cap.delete();
    sent.delete();
    i_npc = 64'h0303030303030303; i_start = 1'b1;
    @(negedge clk);
    i_npc = '0;
    @(negedge clk);
    i_start = 1'b0;
    send_beats(4, 0, 0, got);
    #1;
    chk("midrst_beats", got, 4);
    chk("midrst_writes", cap.size(), 4);
    chk("midrst_en0", cap[0].en, 8'h0F);
    chk("midrst_en3", cap[3].en, 8'hF0);
    chk("midrst_busy", o_busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    rst = 1'b0;
    @(negedge clk);
    run_vec(7, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
